// File: rtl/stop_it_gen_pkg.sv
// Shared types and LFSR tap table for the stop-it reaction game.
package stop_it_gen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStarting,
        StDecrementing,
        StWrong,
        StCorrect,
        StWon
    } state_t;

    typedef logic [1:0] level_t;

    localparam level_t LevelMax = 2'd3;

    // Galois right-shift tap masks for maximal-length sequences, widths 5..8
    function automatic logic [7:0] lfsr_taps(input int unsigned w);
        case (w)
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            default: return 8'hB8;
        endcase
    endfunction

endpackage

// File: rtl/stop_it_gen_if.sv
// Player/display bus of the stop-it game; master drives the controls, slave is the game core.
interface stop_it_gen_if
    import stop_it_gen_pkg::*;
#(
    parameter int unsigned LED_W = 16
) ();

    logic             go;
    logic             stop;
    logic             load;
    level_t           level_sel;
    logic [LED_W-1:0] switches;
    logic [LED_W-1:0] leds;
    logic [3:0]       digit_en;
    logic [3:0][3:0]  digit;
    level_t           level;

    modport master (
        output go, stop, load, level_sel, switches,
        input  leds, digit_en, digit, level
    );

    modport slave (
        input  go, stop, load, level_sel, switches,
        output leds, digit_en, digit, level
    );

endinterface

// File: rtl/stop_it_gen_lfsr_gen.sv
// Maximal-length Galois LFSR that advances while next_i is high; seeded to 1, never reaches 0.
module lfsr_gen
    import stop_it_gen_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk_4_i,
    input  logic         rst_ni,
    input  logic         next_i,
    output logic [W-1:0] rand_o
);

    localparam logic [7:0] Taps = lfsr_taps(W);

    logic [W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (next_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps[W-1:0] : '0);
        end
    end

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_o = lfsr_q;

endmodule

// File: rtl/stop_it_gen.sv
// Stop-it reaction game core: stop a decrementing counter on a random target to fill the LED bar.
// Define STOP_IT_GEN_AUTO_LEVEL_EN to let hits/misses drive the difficulty instead of level_sel.
module stop_it_gen
    import stop_it_gen_pkg::*;
#(
    parameter int unsigned COUNT_W     = 5,
    parameter int unsigned LED_W       = 16,
    parameter int unsigned START_TICKS = 8,
    parameter int unsigned FLASH_TICKS = 16
) (
    input  logic          clk_4_i,
    input  logic          rst_ni,
    stop_it_gen_if.slave  bus
);

    localparam int unsigned TimerW =
        $clog2((START_TICKS > FLASH_TICKS) ? START_TICKS : FLASH_TICKS) + 1;
    localparam logic [TimerW-1:0] StartLast = TimerW'(START_TICKS - 1);
    localparam logic [TimerW-1:0] FlashLast = TimerW'(FLASH_TICKS - 1);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] target_q, target_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [1:0]         div_q, div_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    level_t             level_q, level_d;
    logic [COUNT_W-1:0] rand_val;
    logic               hit;
    logic               state_change;

    lfsr_gen #(
        .W (COUNT_W)
    ) u_lfsr (
        .clk_4_i (clk_4_i),
        .rst_ni  (rst_ni),
        .next_i  (state_q == StIdle),
        .rand_o  (rand_val)
    );

    assign hit          = (cnt_q == target_q);
    assign state_change = (state_d != state_q);

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.go) state_d = StStarting;
                else if (bus.load) state_d = StWon;
            end
            StStarting: begin
                if (bus.load) state_d = StWon;
                else if (timer_q == StartLast) state_d = StDecrementing;
            end
            StDecrementing: begin
                if (bus.stop) state_d = hit ? StCorrect : StWrong;
                else if (bus.load) state_d = StWon;
            end
            StCorrect: begin
                if (timer_q == FlashLast) state_d = (&leds_q) ? StWon : StIdle;
            end
            StWrong, StWon: begin
                if (timer_q == FlashLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        target_d = target_q;
        timer_d  = timer_q;
        div_d    = '0;
        leds_d   = leds_q;
        level_d  = level_q;

        if (state_change) begin
            timer_d = '0;
        end else if (state_q inside {StStarting, StWrong, StCorrect, StWon}) begin
            timer_d = timer_q + 1'b1;
        end

        // The prescaler only runs while staying in DECREMENTING, so a stop cycle never steps
        if (state_q == StDecrementing && !state_change) begin
            if (div_q == (LevelMax - level_q)) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.load) leds_d = bus.switches;
                if (bus.go) target_d = rand_val;
`ifndef STOP_IT_GEN_AUTO_LEVEL_EN
                level_d = bus.level_sel;
`endif
            end
            StDecrementing: begin
                if (bus.stop && hit) begin
                    leds_d = {leds_q[LED_W-2:0], 1'b1};
`ifdef STOP_IT_GEN_AUTO_LEVEL_EN
                    if (level_q != LevelMax) level_d = level_q + 1'b1;
`endif
                end else if (bus.stop) begin
                    leds_d = {1'b0, leds_q[LED_W-1:1]};
`ifdef STOP_IT_GEN_AUTO_LEVEL_EN
                    level_d = '0;
`endif
                end
            end
            StWon: begin
                if (timer_q == FlashLast) leds_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            target_q <= '0;
            timer_q  <= '0;
            div_q    <= '0;
            leds_q   <= '0;
            level_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            div_q    <= div_d;
            leds_q   <= leds_d;
            level_q  <= level_d;
        end
    end

    always_comb begin
        logic [7:0] cnt8;
        logic [7:0] tgt8;
        cnt8 = 8'(cnt_q);
        tgt8 = 8'(target_q);
        bus.digit    = {tgt8[7:4], tgt8[3:0], cnt8[7:4], cnt8[3:0]};
        bus.level    = level_q;
        bus.leds     = leds_q;
        bus.digit_en = 4'b0011;
        unique case (state_q)
            StIdle:                     bus.digit_en = 4'b0011;
            StStarting, StDecrementing: bus.digit_en = 4'b1111;
            StCorrect:                  bus.digit_en = timer_q[0] ? 4'b1111 : 4'b0000;
            StWrong:                    bus.digit_en = timer_q[0] ? 4'b0011 : 4'b1100;
            StWon: begin
                bus.digit_en = timer_q[0] ? 4'b1111 : 4'b0000;
                if (!timer_q[0]) bus.leds = '0;
            end
            default:                    bus.digit_en = 4'b0011;
        endcase
    end

endmodule
